// File: rtl/accel_seq_ctrl.sv
// accel_seq_ctrl: job sequencer that arbitrates RAM<->accelerator bursts for one selected filter.
// Reads and writes alternate under contention; both completion flags end the job through FIN.
module accel_seq_ctrl #(
    parameter int BURST   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  filt_sel,
    input  logic [31:0] offset_in,
    input  logic [31:0] filesize_in,
    input  logic        acc_in_ready,
    input  logic        acc_out_valid,
    input  logic        fft_read_done,
    input  logic        fft_write_done,
    input  logic        fir_read_done,
    input  logic        fir_write_done,
    input  logic        iir_read_done,
    input  logic        iir_write_done,
    output logic [31:0] offset,
    output logic [31:0] filesize,
    output logic        fft_enable,
    output logic        fir_enable,
    output logic        iir_enable,
    output logic        fft_read_pause,
    output logic        fft_write_pause,
    output logic        fir_read_pause,
    output logic        fir_write_pause,
    output logic        iir_read_pause,
    output logic        iir_write_pause,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ARM, READ, WRITE, WAIT, FIN} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sel_q, sel_d;
    logic [31:0]   offset_q, offset_d, filesize_q, filesize_d;
    logic [7:0]    burst_q, burst_d;
    logic [CW-1:0] idle_q, idle_d;
    logic          last_wr_q, last_wr_d;
    logic          rd_done, wr_done, rd_cand, wr_cand, err_c, active;

    assign rd_done = sel_q == 2'd0 ? fft_read_done  : sel_q == 2'd1 ? fir_read_done  : iir_read_done;
    assign wr_done = sel_q == 2'd0 ? fft_write_done : sel_q == 2'd1 ? fir_write_done : iir_write_done;
    assign rd_cand = acc_in_ready & ~rd_done;
    assign wr_cand = acc_out_valid & ~wr_done;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        offset_d   = offset_q;
        filesize_d = filesize_q;
        last_wr_d  = last_wr_q;
        burst_d    = '0;
        idle_d     = '0;
        err_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && filt_sel == 2'd3) begin
                    err_c = 1'b1;
                end else if (start) begin
                    state_d    = ARM;
                    sel_d      = filt_sel;
                    offset_d   = offset_in;
                    filesize_d = filesize_in;
                    last_wr_d  = 1'b1;
                end
            end
            ARM: state_d = WAIT;
            WAIT: begin
                if (rd_cand && (!wr_cand || last_wr_q)) begin
                    state_d   = READ;
                    last_wr_d = 1'b0;
                end else if (wr_cand) begin
                    state_d   = WRITE;
                    last_wr_d = 1'b1;
                end else if (idle_q == CW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    err_c   = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            READ: begin
                if (!rd_cand || burst_q == 8'(BURST - 1)) state_d = WAIT;
                else burst_d = burst_q + 8'd1;
            end
            WRITE: begin
                if (!wr_cand || burst_q == 8'(BURST - 1)) state_d = WAIT;
                else burst_d = burst_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
        // Completion outranks grants and timeout; abort outranks everything.
        if (state_q != IDLE && state_q != FIN && rd_done && wr_done) begin
            state_d = FIN;
            err_c   = 1'b0;
        end
        if (state_q != IDLE && abort) begin
            state_d = IDLE;
            err_c   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= 2'd0;
            offset_q   <= '0;
            filesize_q <= '0;
            burst_q    <= '0;
            idle_q     <= '0;
            last_wr_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            offset_q   <= offset_d;
            filesize_q <= filesize_d;
            burst_q    <= burst_d;
            idle_q     <= idle_d;
            last_wr_q  <= last_wr_d;
        end
    end

    assign active          = state_q == ARM || state_q == READ || state_q == WRITE || state_q == WAIT;
    assign offset          = offset_q;
    assign filesize        = filesize_q;
    assign fft_enable      = active && sel_q == 2'd0;
    assign fir_enable      = active && sel_q == 2'd1;
    assign iir_enable      = active && sel_q == 2'd2;
    assign fft_read_pause  = !(state_q == READ  && sel_q == 2'd0);
    assign fft_write_pause = !(state_q == WRITE && sel_q == 2'd0);
    assign fir_read_pause  = !(state_q == READ  && sel_q == 2'd1);
    assign fir_write_pause = !(state_q == WRITE && sel_q == 2'd1);
    assign iir_read_pause  = !(state_q == READ  && sel_q == 2'd2);
    assign iir_write_pause = !(state_q == WRITE && sel_q == 2'd2);
    assign busy            = state_q != IDLE;
    assign done            = state_q == FIN && !abort;
    assign err             = err_c && rst_n;
endmodule

// File: tb/tb_accel_seq_ctrl.sv
// tb_accel_seq_ctrl: directed and random stimulus against a job-level reference model,
// with expected outputs queued per cycle and compared by an independent monitor.
module tb_accel_seq_ctrl;
    localparam int B = 4;
    localparam int T = 8;
    localparam int P_IDLE = 0, P_ARM = 1, P_RD = 2, P_WR = 3, P_WAIT = 4, P_FIN = 5;

    typedef logic [75:0] obs_t;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [1:0]  filt_sel = 2'd0;
    logic [31:0] offset_in = '0, filesize_in = '0;
    logic        acc_in_ready = 1'b0, acc_out_valid = 1'b0;
    logic [2:0]  rdone = '0, wdone = '0;
    logic [31:0] offset, filesize;
    logic fft_enable, fir_enable, iir_enable, busy, done, err;
    logic fft_read_pause, fft_write_pause, fir_read_pause, fir_write_pause, iir_read_pause, iir_write_pause;
    obs_t act;

    int checks = 0, failures = 0, cyc = 0;
    obs_t exp_q[$];

    int          ph = P_IDLE, jsel = 0, run = 0, starve = 0;
    bit          read_turn = 1'b1;
    logic [31:0] moff = '0, mfsz = '0;

    accel_seq_ctrl #(.BURST(B), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .filt_sel(filt_sel),
        .offset_in(offset_in), .filesize_in(filesize_in),
        .acc_in_ready(acc_in_ready), .acc_out_valid(acc_out_valid),
        .fft_read_done(rdone[0]), .fft_write_done(wdone[0]),
        .fir_read_done(rdone[1]), .fir_write_done(wdone[1]),
        .iir_read_done(rdone[2]), .iir_write_done(wdone[2]),
        .offset(offset), .filesize(filesize),
        .fft_enable(fft_enable), .fir_enable(fir_enable), .iir_enable(iir_enable),
        .fft_read_pause(fft_read_pause), .fft_write_pause(fft_write_pause),
        .fir_read_pause(fir_read_pause), .fir_write_pause(fir_write_pause),
        .iir_read_pause(iir_read_pause), .iir_write_pause(iir_write_pause),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    assign act = {busy, done, err, iir_enable, fir_enable, fft_enable,
                  iir_write_pause, iir_read_pause, fir_write_pause, fir_read_pause,
                  fft_write_pause, fft_read_pause, offset, filesize};

    function automatic obs_t reset_obs();
        return {3'b000, 3'b000, 6'h3F, 64'd0};
    endfunction

    function automatic obs_t predict();
        bit rc, wc, both, b, d, e;
        logic [2:0] en;
        logic [5:0] p;
        if (!rst_n) return reset_obs();
        rc   = acc_in_ready && !rdone[jsel];
        wc   = acc_out_valid && !wdone[jsel];
        both = rdone[jsel] && wdone[jsel];
        b = ph != P_IDLE;
        d = ph == P_FIN && !abort;
        e = (ph == P_IDLE && start && filt_sel == 2'd3) ||
            (ph == P_WAIT && !abort && !both && !rc && !wc && starve == T - 1);
        en = (ph == P_ARM || ph == P_RD || ph == P_WR || ph == P_WAIT) ? 3'(1 << jsel) : 3'b000;
        p = 6'h3F;
        if (ph == P_RD) p[2*jsel] = 1'b0;
        if (ph == P_WR) p[2*jsel+1] = 1'b0;
        return {b, d, e, en, p, moff, mfsz};
    endfunction

    task automatic advance();
        bit rc, wc, both;
        rc   = acc_in_ready && !rdone[jsel];
        wc   = acc_out_valid && !wdone[jsel];
        both = rdone[jsel] && wdone[jsel];
        if (!rst_n) begin
            ph = P_IDLE; moff = '0; mfsz = '0; run = 0; starve = 0; read_turn = 1'b1;
        end else if (ph == P_IDLE) begin
            if (start && filt_sel != 2'd3) begin
                ph = P_ARM; jsel = int'(filt_sel); moff = offset_in; mfsz = filesize_in;
                read_turn = 1'b1; starve = 0;
            end
        end else if (abort) begin
            ph = P_IDLE;
        end else if (both && ph != P_FIN) begin
            ph = P_FIN;
        end else begin
            case (ph)
                P_ARM:  begin ph = P_WAIT; starve = 0; end
                P_WAIT: begin
                    if (rc && (!wc || read_turn)) begin ph = P_RD; run = 1; read_turn = 1'b0; starve = 0; end
                    else if (wc) begin ph = P_WR; run = 1; read_turn = 1'b1; starve = 0; end
                    else begin
                        starve++;
                        if (starve == T) begin ph = P_IDLE; starve = 0; end
                    end
                end
                P_RD: if (!rc || run == B) ph = P_WAIT; else run++;
                P_WR: if (!wc || run == B) ph = P_WAIT; else run++;
                default: ph = P_IDLE;
            endcase
        end
    endtask

    task automatic tick();
        exp_q.push_back(predict());
        advance();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            obs_t e;
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL cycle_outputs cyc=%0d got busy/done/err=%b en=%b pause=%b off=%h fsz=%h expected busy/done/err=%b en=%b pause=%b off=%h fsz=%h",
                         cyc, act[75:73], act[72:70], act[69:64], act[63:32], act[31:0],
                         e[75:73], e[72:70], e[69:64], e[63:32], e[31:0]);
            end
        end
    end

    task automatic go(input logic [1:0] s, input logic [31:0] o, input logic [31:0] f);
        start = 1'b1; filt_sel = s; offset_in = o; filesize_in = f;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int lvl;
        @(posedge clk);
        #1;
        ticks(2);
        rst_n = 1'b1;
        // FIR job with both directions contending for the bus
        acc_in_ready = 1'b1; acc_out_valid = 1'b1;
        go(2'd1, 32'h100, 32'h40);
        ticks(24);
        start = 1'b1; filt_sel = 2'd0; tick(); start = 1'b0;
        rdone[1] = 1'b1; ticks(2);
        wdone[1] = 1'b1; ticks(4);
        rdone = '0; wdone = '0;
        // reserved select
        go(2'd3, 32'hDEAD, 32'hBEEF);
        ticks(3);
        // starvation timeout
        acc_in_ready = 1'b0; acc_out_valid = 1'b0;
        go(2'd0, 32'h2000, 32'h80);
        ticks(14);
        // asynchronous reset mid-READ
        acc_in_ready = 1'b1;
        go(2'd2, 32'h3000, 32'h10);
        ticks(3);
        rst_n = 1'b0;
        #1;
        checks++;
        if (act !== reset_obs()) begin
            failures++;
            $display("FAIL async_reset got %h expected %h", act, reset_obs());
        end
        ticks(2);
        rst_n = 1'b1;
        // abort mid-WRITE
        acc_in_ready = 1'b0; acc_out_valid = 1'b1;
        go(2'd1, 32'h4000, 32'h20);
        ticks(3);
        abort = 1'b1; tick(); abort = 1'b0;
        ticks(3);
        // randomized traffic
        lvl = 2;
        for (int i = 0; i < 2400; i++) begin
            if (i % 150 == 0) lvl = $urandom_range(0, 4);
            start         = $urandom_range(0, 3) == 0;
            filt_sel      = 2'($urandom_range(0, 3));
            offset_in     = $urandom;
            filesize_in   = $urandom;
            abort         = $urandom_range(0, 63) == 0;
            acc_in_ready  = $urandom_range(0, 3) < lvl;
            acc_out_valid = $urandom_range(0, 3) < lvl;
            for (int k = 0; k < 3; k++) begin
                rdone[k] = $urandom_range(0, 7) == 0;
                wdone[k] = $urandom_range(0, 7) == 0;
            end
            if (i == 1200 || i == 2100) begin
                rst_n = 1'b0; tick(); rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
